// File: rtl/pipe_pkg.sv
// pipe_pkg: opcode constants and IF/ID payload shared across the pipeline.
package pipe_pkg;
  localparam logic [1:0] OPC_ADDI = 2'b00;
  localparam logic [1:0] OPC_SLL = 2'b01;
  localparam logic [1:0] OPC_JUMP = 2'b11;
  localparam int PIPE_PC_W = 8;
  localparam int PIPE_INSTR_W = 8;
  typedef struct packed {
    logic [PIPE_PC_W-1:0] pc;
    logic [PIPE_INSTR_W-1:0] instr;
  } if_id_t;
endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: increment, jump decode and target splice for the fetch PC.
module if_next_pc #(
  parameter int PC_W = 8,
  parameter int OPC_W = 2,
  parameter logic [OPC_W-1:0] JUMP_OPC = 2'b11,
  parameter int JT_W = 6
) (
  input  logic [PC_W-1:0]  pc_i,
  input  logic [OPC_W-1:0] opc_i,
  input  logic [JT_W-1:0]  jt_i,
  output logic [PC_W-1:0]  next_pc_o
);
  localparam logic [PC_W-1:0] JT_MASK = {PC_W{1'b1}} >> (PC_W - JT_W);
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  always_comb begin
    pc_inc = pc_i + 1'b1;
    target = (pc_inc & ~JT_MASK) | PC_W'(jt_i);
    next_pc_o = (opc_i == JUMP_OPC) ? target : pc_inc;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register and IF/ID register with valid/ready handshake and redirect flush.
module if_fetch_unit import pipe_pkg::*; #(
  parameter int PC_W = 8,
  parameter int INSTR_W = 8,
  parameter int OPC_W = 2,
  parameter logic [OPC_W-1:0] JUMP_OPC = OPC_JUMP,
  parameter int JT_W = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } payload_t;
  logic [PC_W-1:0] pc_q, pc_d, next_pc;
  logic valid_q, valid_d, advance;
  payload_t pay_q, pay_d;
  if_next_pc #(.PC_W(PC_W), .OPC_W(OPC_W), .JUMP_OPC(JUMP_OPC), .JT_W(JT_W)) u_next_pc (
    .pc_i(pc_q),
    .opc_i(imem_data[INSTR_W-1 -: OPC_W]),
    .jt_i(imem_data[JT_W-1:0]),
    .next_pc_o(next_pc)
  );
  // A redirect still lets decode take the current payload; only the refill is flushed.
  always_comb begin
    advance = !valid_q || out_ready;
    pc_d = redirect_valid ? redirect_pc : advance ? next_pc : pc_q;
    valid_d = redirect_valid ? 1'b0 : advance ? 1'b1 : valid_q;
    pay_d = (advance && !redirect_valid) ? '{pc: pc_q, instr: imem_data} : pay_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      valid_q <= 1'b0;
      pay_q <= '0;
    end else begin
      pc_q <= pc_d;
      valid_q <= valid_d;
      pay_q <= pay_d;
    end
  end
  assign imem_addr = pc_q;
  assign out_valid = valid_q;
  assign out_instr = pay_q.instr;
  assign out_pc = pay_q.pc;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of fetch, jump, wrap, stall, redirect and reset.
module tb_if_fetch_unit;
  logic clk = 1'b0;
  logic reset, redirect_valid, out_ready, out_valid;
  logic [7:0] imem_addr, imem_data, redirect_pc, out_instr, out_pc;
  logic [7:0] rom [256];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  assign imem_data = rom[imem_addr];
  if_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic redirect_to(input logic [7:0] a);
    redirect_valid = 1'b1;
    redirect_pc = a;
    tick();
    chk("redir_valid0", 32'(out_valid), 0);
    chk("redir_addr", 32'(imem_addr), 32'(a));
    redirect_valid = 1'b0;
  endtask
  task automatic expect_out(input string tag, input logic [7:0] pc, input logic [7:0] ins);
    tick();
    chk({tag, "_v"}, 32'(out_valid), 1);
    chk({tag, "_pc"}, 32'(out_pc), 32'(pc));
    chk({tag, "_in"}, 32'(out_instr), 32'(ins));
  endtask
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) & 8'h7F;
    rom[8'h3F] = 8'hC2;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_instr", 32'(out_instr), 0);
    chk("rst_pc", 32'(out_pc), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) expect_out("seq", 8'(i), 8'(i));
    rom[3] = 8'hC5;
    redirect_to(8'h02);
    expect_out("jmp2", 8'h02, 8'h02);
    expect_out("jmp3", 8'h03, 8'hC5);
    expect_out("jmp5", 8'h05, 8'h05);
    redirect_to(8'h3F);
    expect_out("reg3f", 8'h3F, 8'hC2);
    expect_out("reg42", 8'h42, 8'h42);
    redirect_to(8'hFF);
    expect_out("wrapff", 8'hFF, 8'h7F);
    expect_out("wrap00", 8'h00, 8'h00);
    expect_out("pre1", 8'h01, 8'h01);
    expect_out("pre2", 8'h02, 8'h02);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out("stall", 8'h02, 8'h02);
      chk("stall_addr", 32'(imem_addr), 32'h03);
    end
    out_ready = 1'b1;
    expect_out("rel3", 8'h03, 8'hC5);
    expect_out("rel5", 8'h05, 8'h05);
    out_ready = 1'b0;
    redirect_to(8'h80);
    out_ready = 1'b1;
    expect_out("rs80", 8'h80, 8'h00);
    redirect_to(8'h06);
    expect_out("pre6", 8'h06, 8'h06);
    chk("pre_rst_addr", 32'(imem_addr), 32'h07);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_addr", 32'(imem_addr), 0);
    reset = 1'b0;
    expect_out("resume0", 8'h00, 8'h00);
    expect_out("resume1", 8'h01, 8'h01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Parametrised instruction-fetch stage for the 4-stage pipeline. It holds the program counter, drives the instruction-memory address, and registers each fetched instruction with its PC into the IF/ID boundary behind a valid/ready handshake. Unconditional jumps are resolved in-stage with no bubble. A redirect port lets a later stage (branch/exception) flush the fetch and restart at an arbitrary PC.

## Interface
Parameters:
- PC_W, 8, program-counter and memory-address width
- INSTR_W, 8, instruction width
- OPC_W, 2, opcode field width, taken from instr[INSTR_W-1 -: OPC_W]
- JUMP_OPC, 2'b11, opcode value decoded as jump
- JT_W, 6, jump-target field width, taken from instr[JT_W-1:0]; JT_W ≤ PC_W and JT_W ≤ INSTR_W-OPC_W
- RESET_PC, 0, PC loaded on reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears state on the clk edge where it is high
- imem_addr  out  PC_W  instruction-memory address, equals current pc
- imem_data  in  INSTR_W  instruction at imem_addr, combinational, same cycle
- redirect_valid  in  1  later stage requests restart
- redirect_pc  in  PC_W  restart address
- out_valid  out  1  IF/ID register holds a valid instruction
- out_ready  in  1  decode accepts the IF/ID register this cycle
- out_instr  out  INSTR_W  registered instruction
- out_pc  out  PC_W  address out_instr was fetched from

## Operation
- Registered state: pc, out_valid, out_instr, out_pc.
- advance = !out_valid || out_ready (IF/ID register empty or being consumed).
- is_jump = (imem_data opcode == JUMP_OPC).
- pc_inc = pc + 1, modulo 2^PC_W (PC_W'(2^PC_W-1) + 1 = 0).
- jump target = {pc_inc[PC_W-1:JT_W], imem_data[JT_W-1:0]}; with JT_W == PC_W the target is imem_data[PC_W-1:0]. Upper bits come from pc_inc, so a jump at the last address of a region lands in the next region.
- next_pc = is_jump ? jump target : pc_inc.
- Per-edge priority, highest first:
  1. reset: pc ← RESET_PC, out_valid ← 0; out_instr and out_pc ← 0.
  2. redirect_valid: pc ← redirect_pc, out_valid ← 0 (flush). Overrides a stall, and overrides a handshake on the same edge, so the instruction being accepted is still delivered to decode this cycle but is not re-presented.
  3. advance: out_instr ← imem_data, out_pc ← pc, out_valid ← 1, pc ← next_pc.
  4. otherwise (stall: out_valid && !out_ready): all state holds and imem_addr is stable.
- The jump instruction itself is delivered downstream, with out_valid=1, for decode to treat as a no-op. It is never squashed.
- Every opcode value other than JUMP_OPC is sequential.
- No internal X-sources: all registers are reset.

## Timing
- Reset values: imem_addr = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0.
- Fetch latency is 1 cycle: the instruction at imem_addr in cycle n appears on out_instr in cycle n+1.
- First edge after reset deasserts: out_valid=1, out_pc=RESET_PC.
- Throughput is 1 instruction/cycle while out_ready=1, jumps included (zero-bubble jump).
- Redirect penalty is 1 cycle: out_valid=0 in the cycle after the redirect, then the instruction at redirect_pc appears in the following cycle.
- Handshake: out_valid, out_instr and out_pc remain stable while out_valid && !out_ready. out_valid does not depend combinationally on out_ready.
- Reset mid-stall or mid-redirect: reset wins, and the pending instruction is dropped.

## Structure
- Shared package `pipe_pkg`: opcode constants (OPC_ADDI=2'b00, OPC_SLL=2'b01, OPC_JUMP=2'b11), and the IF/ID payload struct {pc, instr}.
- One sub-module, `if_next_pc`: combinational next-PC computation from pc and imem_data (increment, jump decode, target splice).
- Top level contains the registers and the handshake/priority logic.
- Bench instantiates a behavioural ROM for imem.

## Test plan
- Reset, then a ROM of sequential opcodes 00/01 at addresses 0..4 with out_ready=1 → out_pc sequence 0,1,2,3,4 on consecutive cycles; out_valid rises one edge after reset drops.
- Jump: instr 8'hC5 at address 3 → out_pc sequence 2, 3, 5. The 8'hC5 instruction itself is delivered with out_valid=1, and there are no bubbles.
- Region and wrap-around: PC_W=8, instr 8'hC2 at 8'h3F → next out_pc is 8'h42. Sequential code at 8'hFF → next out_pc is 8'h00.
- Stall: out_ready=0 for 3 cycles while out_pc=2 → out_pc, out_instr and imem_addr are held. Releasing out_ready → out_pc 3 follows on the next cycle with no skip and no duplicate.
- Redirect during stall: redirect_valid=1, redirect_pc=8'h80, out_ready=0 → next cycle out_valid=0; the cycle after, out_pc=8'h80.
- Reset asserted for 1 cycle mid-stream (pc=7, out_valid=1) → next cycle out_valid=0 and imem_addr=RESET_PC; fetch then resumes at RESET_PC.
